// File: rtl/tinyodin_obi_initiator.sv
// tinyodin_obi_initiator: sequences word-sized OBI reads/writes into the tinyODIN address window
package tinyodin_obi_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_rsp_t;
endpackage

module tinyodin_obi_initiator #(
    parameter type req_t = tinyodin_obi_pkg::obi_req_t,
    parameter type rsp_t = tinyodin_obi_pkg::obi_rsp_t,
    parameter int  CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [31:0]      cmd_addr_i,
    input  logic [CNT_W-1:0] cmd_len_i,
    input  logic [31:0]      wr_data_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    output logic [31:0]      rd_data_o,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output req_t             obi_req_o,
    input  rsp_t             obi_rsp_i
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} state_t;

    state_t           state_q, state_d;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [CNT_W-1:0] rem_q;
    logic             req_c, fire, last;

    assign req_c       = (state_q == REQ) && (!we_q || wr_valid_i);
    assign fire        = req_c && obi_rsp_i.gnt;
    assign last        = (rem_q == '0);
    assign busy_o      = (state_q != IDLE);
    assign cmd_ready_o = (state_q == IDLE);
    assign wr_ready_o  = fire && we_q;

    // OBI request fields are driven only while a transfer is on offer; zero otherwise
    always_comb begin
        obi_req_o = '0;
        if (state_q == REQ) begin
            obi_req_o.req   = req_c;
            obi_req_o.we    = we_q;
            obi_req_o.be    = 4'hF;
            obi_req_o.addr  = addr_q;
            obi_req_o.wdata = wr_data_i;
        end
    end

    // next-state: one outstanding transfer, reads park in DRAIN until the local side takes the word
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (cmd_valid_i && cmd_len_i != '0) ? REQ : IDLE;
            REQ:     state_d = fire ? RESP : REQ;
            RESP:    state_d = !obi_rsp_i.rvalid ? RESP : !we_q ? DRAIN : last ? IDLE : REQ;
            DRAIN:   state_d = !rd_ready_i ? DRAIN : last ? IDLE : REQ;
            default: state_d = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // command latch, address/count stepping on each grant, read-word holding and done pulse
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            we_q       <= 1'b0;
            addr_q     <= '0;
            rem_q      <= '0;
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (state_q == IDLE && cmd_valid_i) begin
                we_q   <= cmd_we_i;
                addr_q <= cmd_addr_i & 32'hFFFF_FFFC;
                rem_q  <= cmd_len_i;
                done_o <= (cmd_len_i == '0);
            end
            if (fire) begin
                addr_q <= addr_q + 32'd4;
                rem_q  <= rem_q - CNT_W'(1);
            end
            if (state_q == RESP && obi_rsp_i.rvalid) begin
                if (we_q) begin
                    done_o <= last;
                end else begin
                    rd_data_o  <= obi_rsp_i.rdata;
                    rd_valid_o <= 1'b1;
                end
            end
            if (state_q == DRAIN && rd_ready_i) begin
                rd_valid_o <= 1'b0;
                done_o     <= last;
            end
        end
    end
endmodule

// File: tb/tb_tinyodin_obi_initiator.sv
// tb_tinyodin_obi_initiator: scoreboard bench with a behavioural OBI slave and local stream models
module tb_tinyodin_obi_initiator;
    import tinyodin_obi_pkg::*;

    localparam int CW = 8;

    logic          CLK = 1'b0;
    logic          RSTN;
    logic          cmd_valid_i, cmd_we_i;
    logic          cmd_ready_o;
    logic [31:0]   cmd_addr_i;
    logic [CW-1:0] cmd_len_i;
    logic [31:0]   wr_data_i;
    logic          wr_valid_i, wr_ready_o;
    logic [31:0]   rd_data_o;
    logic          rd_valid_o, rd_ready_i;
    logic          busy_o, done_o;
    obi_req_t      obi_req;
    obi_rsp_t      obi_rsp;

    always #5 CLK = ~CLK;

    tinyodin_obi_initiator #(.CNT_W(CW)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
        .busy_o(busy_o), .done_o(done_o),
        .obi_req_o(obi_req), .obi_rsp_i(obi_rsp)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } xfer_t;

    xfer_t       exp_req[$];
    logic [31:0] exp_rd[$];
    logic [31:0] wq[$];
    logic [31:0] dir_words[$];

    int tests = 0, fails = 0;
    int n_fire, n_wrr, n_rdh, n_done;
    bit cur_we, rand_mode, rsp_pending;
    int gnt_dly, gnt_wait, rv_fix, rsp_wait;
    int src_gap, gap_at, gap_len, rd_hold;
    logic [31:0] rsp_addr;

    // slave memory contents: two fixed words, the rest derived from the address
    function automatic logic [31:0] slave_val(input logic [31:0] a);
        return a == 32'h0030_0000 ? 32'h0000_1234 : a == 32'h0030_0004 ? 32'h0000_5678 : a ^ 32'hC0DE_5A5A;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // stimulus driver: slave gnt/rvalid, write-word source, read-word sink
    initial begin
        obi_rsp = '0;
        wr_valid_i = 1'b0;
        wr_data_i = '0;
        rd_ready_i = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            obi_rsp.rvalid = 1'b0;
            if (rsp_pending) begin
                if (rsp_wait <= 1) begin
                    obi_rsp.rvalid = 1'b1;
                    obi_rsp.rdata = slave_val(rsp_addr);
                    rsp_pending = 1'b0;
                end else rsp_wait--;
            end
            if (wq.size() > 0 && src_gap == 0) begin
                wr_valid_i = 1'b1;
                wr_data_i = wq[0];
            end else begin
                wr_valid_i = 1'b0;
                if (src_gap > 0) src_gap--;
            end
            if (rd_valid_o && rd_hold > 0) begin
                rd_ready_i = 1'b0;
                rd_hold--;
            end else rd_ready_i = rd_valid_o && (!rand_mode || $urandom_range(0, 1) == 1);
            #1;
            obi_rsp.gnt = obi_req.req && gnt_wait >= gnt_dly;
            if (obi_req.req && !obi_rsp.gnt) gnt_wait++;
        end
    end

    // monitor: pops the scoreboard whenever the DUT presents a transfer, word or done pulse
    initial begin : mon
        xfer_t    x;
        bit       fire, prev_stall;
        obi_req_t prev_req;
        prev_stall = 1'b0;
        prev_req = '0;
        forever begin
            @(posedge CLK);
            #4;
            if (!RSTN) prev_stall = 1'b0;
            else begin
                fire = obi_req.req && obi_rsp.gnt;
                if (prev_stall)
                    chk(obi_req.req && obi_req.addr == prev_req.addr && obi_req.we == prev_req.we &&
                        obi_req.wdata == prev_req.wdata, "req_stable", obi_req.addr, prev_req.addr);
                prev_stall = obi_req.req && !obi_rsp.gnt;
                prev_req = obi_req;
                if (fire) begin
                    if (exp_req.size() == 0) chk(1'b0, "unexpected_req", obi_req.addr, 32'h0);
                    else begin
                        x = exp_req.pop_front();
                        chk(obi_req.addr == x.addr, "req_addr", obi_req.addr, x.addr);
                        chk(obi_req.we == x.we && obi_req.be == 4'hF, "req_we_be",
                            32'({obi_req.we, obi_req.be}), 32'({x.we, 4'hF}));
                        if (x.we) chk(obi_req.wdata == x.wdata, "req_wdata", obi_req.wdata, x.wdata);
                    end
                    n_fire++;
                    rsp_pending = 1'b1;
                    rsp_addr = obi_req.addr;
                    rsp_wait = rand_mode ? int'($urandom_range(1, 3)) : rv_fix;
                    gnt_wait = 0;
                    if (rand_mode) gnt_dly = int'($urandom_range(0, 2));
                end
                chk(wr_ready_o == (fire && cur_we), "wr_ready_pulse", 32'(wr_ready_o), 32'(fire && cur_we));
                if (wr_ready_o) begin
                    n_wrr++;
                    if (wq.size() > 0) void'(wq.pop_front());
                    src_gap = (n_wrr == gap_at) ? gap_len : rand_mode ? int'($urandom_range(0, 2)) : 0;
                end
                if (obi_req.req && cur_we) chk(wr_valid_i, "req_without_wr_valid", 32'(wr_valid_i), 32'h1);
                if (rd_valid_o) begin
                    chk(!obi_req.req, "req_while_rd_valid", 32'(obi_req.req), 32'h0);
                    if (exp_rd.size() == 0) chk(1'b0, "unexpected_rd", rd_data_o, 32'h0);
                    else chk(rd_data_o == exp_rd[0], "rd_data", rd_data_o, exp_rd[0]);
                    if (rd_ready_i) begin
                        if (exp_rd.size() > 0) void'(exp_rd.pop_front());
                        n_rdh++;
                    end
                end
                if (done_o) begin
                    n_done++;
                    chk(!busy_o, "busy_at_done", 32'(busy_o), 32'h0);
                end
            end
        end
    end

    // reference model: a sequence is len words at consecutive word addresses from the aligned base
    task automatic issue(input logic we, input logic [31:0] addr, input int len);
        logic [31:0] a, w;
        a = addr & 32'hFFFF_FFFC;
        n_fire = 0; n_wrr = 0; n_rdh = 0; n_done = 0;
        cur_we = we;
        for (int i = 0; i < len; i++) begin
            w = dir_words.size() > 0 ? dir_words.pop_front() : $urandom;
            exp_req.push_back('{addr: a, we: we, wdata: w});
            if (we) wq.push_back(w);
            else exp_rd.push_back(slave_val(a));
            a = a + 32'd4;
        end
        @(posedge CLK);
        #1;
        chk(cmd_ready_o, "cmd_ready_idle", 32'(cmd_ready_o), 32'h1);
        cmd_valid_i = 1'b1;
        cmd_we_i = we;
        cmd_addr_i = addr;
        cmd_len_i = CW'(len);
        @(posedge CLK);
        #1;
        cmd_valid_i = 1'b0;
        cmd_addr_i = $urandom;
        cmd_len_i = CW'($urandom);
        #3;
        chk(busy_o == (len != 0), "busy_after_accept", 32'(busy_o), 32'(len != 0));
    endtask

    task automatic finish_cmd(input logic we, input int len);
        int cyc;
        bit seen;
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 2000) begin
            if (done_o) begin
                seen = 1'b1;
                if (len == 0) chk(cyc == 0, "done_latency_len0", 32'(cyc), 32'h0);
            end else begin
                @(posedge CLK);
                #4;
                cyc++;
            end
        end
        if (!seen) chk(1'b0, "done_timeout", 32'(cyc), 32'd2000);
        repeat (3) @(posedge CLK);
        #4;
        chk(n_done == 1, "done_once", 32'(n_done), 32'h1);
        chk(n_fire == len, "xfer_count", 32'(n_fire), 32'(len));
        chk(n_wrr == (we ? len : 0), "wr_ready_count", 32'(n_wrr), 32'(we ? len : 0));
        chk(n_rdh == (we ? 0 : len), "rd_count", 32'(n_rdh), 32'(we ? 0 : len));
        chk(!busy_o, "busy_after_done", 32'(busy_o), 32'h0);
        chk(exp_req.size() == 0 && exp_rd.size() == 0, "queues_drained",
            32'(exp_req.size() + exp_rd.size()), 32'h0);
    endtask

    task automatic run_cmd(input logic we, input logic [31:0] addr, input int len);
        issue(we, addr, len);
        finish_cmd(we, len);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(obi_req == '0, {tag, "_obi_req"}, obi_req.addr, 32'h0);
        chk(rd_data_o == 32'h0 && !rd_valid_o, {tag, "_rd"}, rd_data_o, 32'h0);
        chk(!wr_ready_o && !done_o && !busy_o, {tag, "_pulses"}, 32'({wr_ready_o, done_o, busy_o}), 32'h0);
        chk(cmd_ready_o, {tag, "_cmd_ready"}, 32'(cmd_ready_o), 32'h1);
    endtask

    initial begin
        int cyc;
        RSTN = 1'b0;
        cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
        rand_mode = 1'b0; rsp_pending = 1'b0; cur_we = 1'b0;
        gnt_dly = 0; gnt_wait = 0; rv_fix = 1; rsp_wait = 0;
        src_gap = 0; gap_at = -1; gap_len = 0; rd_hold = 0;
        repeat (2) @(posedge CLK);
        #4;
        chk_reset_outputs("reset");
        #2;
        RSTN = 1'b1;

        dir_words = '{32'hA, 32'hB, 32'hC};
        run_cmd(1'b1, 32'h0010_0000, 3);

        rd_hold = 5;
        run_cmd(1'b0, 32'h0030_0000, 2);

        gnt_dly = 4;
        run_cmd(1'b1, 32'h0020_0040, 1);
        gnt_dly = 0;

        run_cmd(1'b1, 32'h0000_0100, 0);

        gap_at = 2; gap_len = 3;
        run_cmd(1'b1, 32'h0010_0100, 5);
        gap_at = -1;

        run_cmd(1'b1, 32'hFFFF_FFFA, 3);
        run_cmd(1'b0, 32'h0020_0000, 255);

        rv_fix = 8;
        issue(1'b0, 32'h0020_0000, 4);
        cyc = 0;
        while (n_fire < 1 && cyc < 100) begin
            @(posedge CLK);
            #4;
            cyc++;
        end
        if (n_fire < 1) chk(1'b0, "reset_test_timeout", 32'(cyc), 32'd100);
        @(posedge CLK);
        #2;
        RSTN = 1'b0;
        #1;
        rsp_pending = 1'b0;
        exp_req.delete(); exp_rd.delete(); wq.delete();
        chk_reset_outputs("midseq_reset");
        repeat (2) @(posedge CLK);
        #2;
        RSTN = 1'b1;
        rv_fix = 1;
        run_cmd(1'b0, 32'h0000_0000, 2);

        rand_mode = 1'b1;
        repeat (25) run_cmd(1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 6)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
